// File: rtl/bcd_operand_loader.sv
// Collects four BCD digits (hundreds, tens, units, divisor) and holds them for the checker until ack.
// Optional BCD_REJECT_EN: non-BCD digits are consumed without storing and flagged on badDigit.
module bcd_operand_loader (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] digitIn,
  input  logic       digitValid,
  output logic       digitReady,
  input  logic       clear,
  input  logic       ack,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic       operandsValid,
  output logic [2:0] digitCount,
  output logic       badDigit
);

  typedef enum logic [1:0] {StEmpty, StCollect, StFull} state_e;

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic       bad_q, bad_d;
  logic       accept;
  logic       is_bad;

  assign accept = digitValid && (state_q != StFull);

`ifdef BCD_REJECT_EN
  assign is_bad = (digitIn > 4'd9);
`else
  assign is_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    bad_d   = 1'b0;
    if (clear) begin
      state_d = StEmpty;
      count_d = 3'd0;
      a_d     = 4'd0;
      b_d     = 4'd0;
      c_d     = 4'd0;
      d_d     = 4'd0;
    end else if (ack && (state_q == StFull)) begin
      // Operands are left in place; only the handshake state re-arms.
      state_d = StEmpty;
      count_d = 3'd0;
    end else if (accept) begin
      if (is_bad) begin
        bad_d = 1'b1;
      end else begin
        unique case (count_q[1:0])
          2'd0: a_d = digitIn;
          2'd1: b_d = digitIn;
          2'd2: c_d = digitIn;
          2'd3: d_d = digitIn;
        endcase
        count_d = count_q + 3'd1;
        state_d = (count_q == 3'd3) ? StFull : StCollect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= StEmpty;
      count_q <= 3'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      c_q     <= 4'd0;
      d_q     <= 4'd0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      bad_q   <= bad_d;
    end
  end

  assign digitReady    = (state_q != StFull);
  assign operandsValid = (state_q == StFull);
  assign digitCount    = count_q;
  assign a             = a_q;
  assign b             = b_q;
  assign c             = c_q;
  assign d             = d_q;
`ifdef BCD_REJECT_EN
  assign badDigit      = bad_q;
`else
  assign badDigit      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed bench for bcd_operand_loader: stimulus queues expected post-edge state, a monitor compares.
module tb_bcd_operand_loader;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] digitIn = 4'd0;
  logic       digitValid = 1'b0;
  logic       digitReady;
  logic       clear = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] a, b, c, d;
  logic       operandsValid;
  logic [2:0] digitCount;
  logic       badDigit;

  bcd_operand_loader dut (
    .clk          (clk),
    .resetN       (resetN),
    .digitIn      (digitIn),
    .digitValid   (digitValid),
    .digitReady   (digitReady),
    .clear        (clear),
    .ack          (ack),
    .a            (a),
    .b            (b),
    .c            (c),
    .d            (d),
    .operandsValid(operandsValid),
    .digitCount   (digitCount),
    .badDigit     (badDigit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] ea, eb, ec, ed;
    logic       ev;
    logic       er;
    logic [2:0] en;
    logic       ebad;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cycle = cycle + 1;

  // Monitor: compares every queued expectation due at this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec = n_vec + 1;
      if (e.cyc != cycle || a !== e.ea || b !== e.eb || c !== e.ec || d !== e.ed ||
          operandsValid !== e.ev || digitReady !== e.er || digitCount !== e.en ||
          badDigit !== e.ebad) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got a=%0d b=%0d c=%0d d=%0d v=%b rdy=%b n=%0d bad=%b, want a=%0d b=%0d c=%0d d=%0d v=%b rdy=%b n=%0d bad=%b (due cyc %0d at %0d)",
                 e.name, a, b, c, d, operandsValid, digitReady, digitCount, badDigit,
                 e.ea, e.eb, e.ec, e.ed, e.ev, e.er, e.en, e.ebad, e.cyc, cycle);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge that samples them.
  task automatic apply(input logic rn, input logic clr, input logic ak, input logic dv,
                       input logic [3:0] din, input logic [3:0] ea, input logic [3:0] eb,
                       input logic [3:0] ec, input logic [3:0] ed, input logic ev,
                       input logic [2:0] en, input logic ebad, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    resetN     = rn;
    clear      = clr;
    ack        = ak;
    digitValid = dv;
    digitIn    = din;
    e.cyc  = cycle + 1;
    e.ea   = ea;
    e.eb   = eb;
    e.ec   = ec;
    e.ed   = ed;
    e.ev   = ev;
    e.er   = !ev;
    e.en   = en;
    e.ebad = ebad;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset held two cycles, then 1,2,6,3 back to back.
    apply(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, "reset0");
    apply(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, "reset1");
    apply(1, 0, 0, 1, 4'd1, 1, 0, 0, 0, 0, 3'd1, 0, "entry_d1");
    apply(1, 0, 0, 1, 4'd2, 1, 2, 0, 0, 0, 3'd2, 0, "entry_d2");
    apply(1, 0, 0, 1, 4'd6, 1, 2, 6, 0, 0, 3'd3, 0, "entry_d3");
    apply(1, 0, 0, 1, 4'd3, 1, 2, 6, 3, 1, 3'd4, 0, "entry_full");

    // ack re-arms without clearing operands, then fill with 9s and hold.
    apply(1, 0, 1, 0, 4'd0, 1, 2, 6, 3, 0, 3'd0, 0, "ack_rearm");
    apply(1, 0, 0, 1, 4'd9, 9, 2, 6, 3, 0, 3'd1, 0, "nines_1");
    apply(1, 0, 0, 1, 4'd9, 9, 9, 6, 3, 0, 3'd2, 0, "nines_2");
    apply(1, 0, 0, 1, 4'd9, 9, 9, 9, 3, 0, 3'd3, 0, "nines_3");
    apply(1, 0, 0, 1, 4'd9, 9, 9, 9, 9, 1, 3'd4, 0, "nines_full");
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 1, 4'd5, 9, 9, 9, 9, 1, 3'd4, 0, "hold_full");
    end
    apply(1, 0, 1, 0, 4'd0, 9, 9, 9, 9, 0, 3'd0, 0, "hold_ack");
    apply(1, 0, 0, 0, 4'd0, 9, 9, 9, 9, 0, 3'd0, 0, "idle_empty");

    // Clear mid-entry drops the concurrent digit and zeroes operands.
    apply(1, 0, 0, 1, 4'd4, 4, 9, 9, 9, 0, 3'd1, 0, "clr_d1");
    apply(1, 0, 0, 1, 4'd0, 4, 0, 9, 9, 0, 3'd2, 0, "clr_d2");
    apply(1, 1, 0, 1, 4'd7, 0, 0, 0, 0, 0, 3'd0, 0, "clear_drop");
    // ack outside FULL is ignored; the digit is still taken.
    apply(1, 0, 1, 1, 4'd8, 8, 0, 0, 0, 0, 3'd1, 0, "ack_ignored");
    apply(1, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, "clear_again");

    // Reset in FULL discards everything.
    apply(1, 0, 0, 1, 4'd0, 0, 0, 0, 0, 0, 3'd1, 0, "rstfull_d1");
    apply(1, 0, 0, 1, 4'd4, 0, 4, 0, 0, 0, 3'd2, 0, "rstfull_d2");
    apply(1, 0, 0, 1, 4'd0, 0, 4, 0, 0, 0, 3'd3, 0, "rstfull_d3");
    apply(1, 0, 0, 1, 4'd0, 0, 4, 0, 0, 1, 3'd4, 0, "rstfull_full");
    apply(0, 0, 1, 1, 4'd5, 0, 0, 0, 0, 0, 3'd0, 0, "rst_in_full");

    // Non-BCD digit handling.
`ifdef BCD_REJECT_EN
    apply(1, 0, 0, 1, 4'd3,  3, 0, 0, 0, 0, 3'd1, 0, "nbcd_3");
    apply(1, 0, 0, 1, 4'd12, 3, 0, 0, 0, 0, 3'd1, 1, "nbcd_12_rej");
    apply(1, 0, 0, 1, 4'd5,  3, 5, 0, 0, 0, 3'd2, 0, "nbcd_5");
    apply(1, 0, 0, 1, 4'd7,  3, 5, 7, 0, 0, 3'd3, 0, "nbcd_7");
    apply(1, 0, 0, 1, 4'd1,  3, 5, 7, 1, 1, 3'd4, 0, "nbcd_full");
`else
    apply(1, 0, 0, 1, 4'd3,  3, 0,  0, 0, 0, 3'd1, 0, "nbcd_3");
    apply(1, 0, 0, 1, 4'd12, 3, 12, 0, 0, 0, 3'd2, 0, "nbcd_12_kept");
    apply(1, 0, 0, 1, 4'd5,  3, 12, 5, 0, 0, 3'd3, 0, "nbcd_5");
    apply(1, 0, 0, 1, 4'd7,  3, 12, 5, 7, 1, 3'd4, 0, "nbcd_full");
    apply(1, 0, 0, 1, 4'd1,  3, 12, 5, 7, 1, 3'd4, 0, "nbcd_ignored");
`endif

    // clear outranks ack in FULL.
    apply(1, 1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, "clear_over_ack");
    apply(1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, "final_idle");

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
